r2fft_ostream: RTL and testbench

Output streamer directly downstream of the R2FFT core. When a frame completes, it drains the FFT result buffer through the core's DMA read port and presents the frame as a valid/ready sample stream, in natural or bit-reversed address order. Each beat carries its index, a last-beat flag and the frame's block-floating-point exponent. It hides the one-cycle DMA read latency behind a 2-entry output buffer and sustains one beat per cycle while the sink is ready.

---
 rtl/r2fft_ostream.sv | 139 +++++++++++++
 tb/tb_r2fft_ostream.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2fft_ostream.sv
// r2fft_ostream: drains the R2FFT result buffer over the DMA read port
// and streams the frame as valid/ready beats with index and exponent.
module r2fft_ostream #(
  parameter int FFT_LENGTH = 1024,
  parameter int FFT_DW = 16,
  parameter int BITREV = 0,
  parameter int FFT_N = $clog2(FFT_LENGTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic done,
  input  logic signed [7:0] bfpexp,
  output logic dmaact,
  output logic [FFT_N-1:0] dmaa,
  input  logic signed [FFT_DW-1:0] dmadr_real,
  input  logic signed [FFT_DW-1:0] dmadr_imag,
  output logic m_valid,
  input  logic m_ready,
  output logic signed [FFT_DW-1:0] m_real,
  output logic signed [FFT_DW-1:0] m_imag,
  output logic [FFT_N-1:0] m_index,
  output logic m_last,
  output logic signed [7:0] m_bfpexp,
  output logic busy,
  output logic drained,
  output logic ovr
);
  typedef struct packed {
    logic [FFT_DW-1:0] re;
    logic [FFT_DW-1:0] im;
    logic [FFT_N-1:0] idx;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  localparam logic [FFT_N-1:0] LAST = FFT_N'(FFT_LENGTH - 1);

  state_t state, state_nx;
  logic done_q, rise;
  logic [FFT_N-1:0] rc, fl_idx;
  logic inflight;
  logic [1:0] cnt, occ, cnt_nx;
  ent_t e0, e1, inc, l0, l1, head;
  logic pop, issue, fin;

  function automatic logic [FFT_N-1:0] bitrev(
    input logic [FFT_N-1:0] a
  );
    logic [FFT_N-1:0] r;
    for (int i = 0; i < FFT_N; i++)
      r[i] = a[FFT_N-1-i];
    return r;
  endfunction

  assign rise = done & ~done_q;
  assign inc = '{re: dmadr_real, im: dmadr_imag, idx: fl_idx};
  assign occ = cnt + {1'b0, inflight};
  assign cnt_nx = occ - {1'b0, pop};

  // read data in flight is visible at once, hiding the DMA latency
  assign m_valid = (cnt != 2'd0) | inflight;
  assign head = (cnt != 2'd0) ? e0 : inc;
  assign pop = m_valid & m_ready;
  assign issue = (state == STREAM) & ((occ < 2'd2) | pop);
  assign fin = (state == FLUSH) & (cnt_nx == 2'd0);

  assign dmaact = issue;
  assign dmaa = !issue ? '0 :
                (BITREV != 0) ? bitrev(rc) : rc;

  assign m_real = m_valid ? head.re : '0;
  assign m_imag = m_valid ? head.im : '0;
  assign m_index = m_valid ? head.idx : '0;
  assign m_last = m_valid & (head.idx == LAST);
  assign busy = (state != IDLE);

  // queue order: stored entries first, then the arriving read
  always_comb begin
    l0 = e0;
    l1 = e1;
    case (cnt)
      2'd0: l0 = inc;
      2'd1: l1 = inc;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (rise) state_nx = STREAM;
      STREAM: if (issue && rc == LAST) state_nx = FLUSH;
      FLUSH: if (fin) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done_q <= 1'b0;
      rc <= '0;
      fl_idx <= '0;
      inflight <= 1'b0;
      cnt <= 2'd0;
      e0 <= '0;
      e1 <= '0;
      m_bfpexp <= '0;
      drained <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_nx;
      done_q <= done;
      drained <= fin;
      inflight <= issue;
      cnt <= cnt_nx;
      if (issue) begin
        fl_idx <= rc;
        rc <= rc + 1'b1;
      end
      if (state == IDLE && rise) begin
        m_bfpexp <= bfpexp;
        rc <= '0;
      end
      if (state != IDLE && rise) ovr <= 1'b1;
      if (pop) begin
        e0 <= l1;
        e1 <= l1;
      end else begin
        e0 <= l0;
        e1 <= l1;
      end
    end
  end
endmodule

// File: tb/tb_r2fft_ostream.sv
// tb_r2fft_ostream: directed vectors for the FFT output streamer
// using N=8 natural/bit-reversed instances and an N=1024 instance.
module tb_r2fft_ostream;
  logic clk = 1'b0;
  logic rst, done, done2, m_ready, ready2;
  logic signed [7:0] bfpexp;

  logic dmaact0, m_valid0, m_last0, busy0, drained0, ovr0;
  logic [2:0] dmaa0, m_index0;
  logic signed [15:0] dr0_re, dr0_im, m_real0, m_imag0;
  logic signed [7:0] m_bfp0;

  logic dmaact1, m_valid1, m_last1, busy1, drained1, ovr1;
  logic [2:0] dmaa1, m_index1;
  logic signed [15:0] dr1_re, dr1_im, m_real1, m_imag1;
  logic signed [7:0] m_bfp1;

  logic dmaact2, m_valid2, m_last2, busy2, drained2, ovr2;
  logic [9:0] dmaa2, m_index2;
  logic signed [15:0] dr2_re, dr2_im, m_real2, m_imag2;
  logic signed [7:0] m_bfp2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (dmaact0) begin
      dr0_re <= 16'(dmaa0);
      dr0_im <= -16'(dmaa0);
    end
    if (dmaact1) begin
      dr1_re <= 16'(dmaa1);
      dr1_im <= -16'(dmaa1);
    end
    if (dmaact2) begin
      dr2_re <= 16'(dmaa2);
      dr2_im <= -16'(dmaa2);
    end
  end

  r2fft_ostream #(.FFT_LENGTH(8), .FFT_DW(16), .BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .done(done), .bfpexp(bfpexp),
    .dmaact(dmaact0), .dmaa(dmaa0),
    .dmadr_real(dr0_re), .dmadr_imag(dr0_im),
    .m_valid(m_valid0), .m_ready(m_ready),
    .m_real(m_real0), .m_imag(m_imag0), .m_index(m_index0),
    .m_last(m_last0), .m_bfpexp(m_bfp0), .busy(busy0),
    .drained(drained0), .ovr(ovr0)
  );

  r2fft_ostream #(.FFT_LENGTH(8), .FFT_DW(16), .BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .done(done), .bfpexp(bfpexp),
    .dmaact(dmaact1), .dmaa(dmaa1),
    .dmadr_real(dr1_re), .dmadr_imag(dr1_im),
    .m_valid(m_valid1), .m_ready(m_ready),
    .m_real(m_real1), .m_imag(m_imag1), .m_index(m_index1),
    .m_last(m_last1), .m_bfpexp(m_bfp1), .busy(busy1),
    .drained(drained1), .ovr(ovr1)
  );

  r2fft_ostream #(.FFT_LENGTH(1024), .FFT_DW(16), .BITREV(0)) dut2 (
    .clk(clk), .rst(rst), .done(done2), .bfpexp(bfpexp),
    .dmaact(dmaact2), .dmaa(dmaa2),
    .dmadr_real(dr2_re), .dmadr_imag(dr2_im),
    .m_valid(m_valid2), .m_ready(ready2),
    .m_real(m_real2), .m_imag(m_imag2), .m_index(m_index2),
    .m_last(m_last2), .m_bfpexp(m_bfp2), .busy(busy2),
    .drained(drained2), .ovr(ovr2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero0(input string nm);
    chk({nm, "_dmaact"}, dmaact0, 0);
    chk({nm, "_dmaa"}, dmaa0, 0);
    chk({nm, "_valid"}, m_valid0, 0);
    chk({nm, "_real"}, m_real0, 0);
    chk({nm, "_imag"}, m_imag0, 0);
    chk({nm, "_index"}, m_index0, 0);
    chk({nm, "_last"}, m_last0, 0);
    chk({nm, "_bfp"}, m_bfp0, 0);
    chk({nm, "_busy"}, busy0, 0);
    chk({nm, "_drained"}, drained0, 0);
    chk({nm, "_ovr"}, ovr0, 0);
  endtask

  // mode 0: stall at index 3; 1: exponent change + second done edge;
  // 2: plain frame
  task automatic run0(input int mode);
    int exp_i = 0;
    int issued = 0;
    int stall = 0;
    int drn = 0;
    int cyc = 0;
    bit seen3 = 1'b0;
    done = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    done = 1'b1;
    while (drn == 0 && cyc < 60) begin
      @(negedge clk);
      if (mode == 1 && cyc == 3) bfpexp = 8'sd5;
      if (mode == 1 && cyc == 4) done = 1'b0;
      if (mode == 1 && cyc == 5) done = 1'b1;
      if (mode == 0 && exp_i == 3 && !seen3) begin
        seen3 = 1'b1;
        stall = 5;
      end
      m_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("stall_valid", m_valid0, 1);
        chk("stall_index", m_index0, 3);
        chk("stall_real", m_real0, 3);
        stall--;
      end
      if (m_valid0 && m_ready) begin
        chk("beat_index", m_index0, exp_i);
        chk("beat_real", m_real0, exp_i);
        chk("beat_last", m_last0, exp_i == 7);
        if (mode == 1) chk("beat_bfp", m_bfp0, -3);
        exp_i++;
      end
      if (dmaact0) issued++;
      chk("reads_ahead", (issued - exp_i) <= 2, 1);
      if (drained0) drn++;
      cyc++;
    end
    chk("frame_beats", exp_i, 8);
    chk("frame_reads", issued, 8);
    chk("frame_drained", drn, 1);
    chk("frame_busy_end", busy0, 0);
    chk("frame_ovr", ovr0, mode == 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("after_drained", drained0, 0);
      chk("after_busy", busy0, 0);
    end
    if (mode == 1) chk("ovr_bfp", m_bfp0, -3);
  endtask

  typedef struct {
    bit act;
    int a0;
    int a1;
    bit mv;
    int idx;
    int r1;
    bit last;
    bit busy;
    bit drn;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 1, 4, 1, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 2, 2, 1, 1, 4, 0, 1, 0};
    tbl[3]  = '{1, 3, 6, 1, 2, 2, 0, 1, 0};
    tbl[4]  = '{1, 4, 1, 1, 3, 6, 0, 1, 0};
    tbl[5]  = '{1, 5, 5, 1, 4, 1, 0, 1, 0};
    tbl[6]  = '{1, 6, 3, 1, 5, 5, 0, 1, 0};
    tbl[7]  = '{1, 7, 7, 1, 6, 3, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 7, 7, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b0;
    done = 1'b0;
    done2 = 1'b0;
    m_ready = 1'b1;
    ready2 = 1'b1;
    bfpexp = 8'sd7;
    repeat (2) @(negedge clk);
    chk_zero0("reset");
    rst = 1'b1;
    @(negedge clk);

    // full-rate frame, done rises before edge T
    done = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("t_dmaact", dmaact0, tbl[k].act);
      chk("t_dmaa0", dmaa0, tbl[k].a0);
      chk("t_dmaa1", dmaa1, tbl[k].a1);
      chk("t_valid", m_valid0, tbl[k].mv);
      chk("t_index", m_index0, tbl[k].idx);
      chk("t_real", m_real0, tbl[k].idx);
      chk("t_imag", m_imag0, tbl[k].mv ? -tbl[k].idx : 0);
      chk("t_last", m_last0, tbl[k].last);
      chk("t_busy", busy0, tbl[k].busy);
      chk("t_drained", drained0, tbl[k].drn);
      chk("t_br_valid", m_valid1, tbl[k].mv);
      chk("t_br_index", m_index1, tbl[k].idx);
      chk("t_br_real", m_real1, tbl[k].r1);
      chk("t_br_last", m_last1, tbl[k].last);
    end
    chk("t_bfp", m_bfp0, 7);
    chk("t_ovr", ovr0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_done_busy", busy0, 0);
    end

    bfpexp = 8'sd2;
    run0(0);

    begin
      int exp_i = 0;
      int issued = 0;
      int lasts = 0;
      int drn = 0;
      int cyc = 0;
      @(negedge clk);
      done2 = 1'b1;
      while (drn == 0 && cyc < 6000) begin
        @(negedge clk);
        ready2 = 1'($urandom_range(0, 1));
        #1;
        if (m_valid2 && ready2) begin
          if (m_index2 != 10'(exp_i) || m_real2 != 16'(exp_i))
            chk("rand_order", m_index2, exp_i);
          if (m_last2) lasts++;
          exp_i++;
        end
        if (dmaact2) issued++;
        if ((issued - exp_i) > 2)
          chk("rand_ahead", issued - exp_i, 2);
        if (drained2) drn++;
        cyc++;
      end
      ready2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (drained2) drn++;
      end
      chk("rand_beats", exp_i, 1024);
      chk("rand_reads", issued, 1024);
      chk("rand_lasts", lasts, 1);
      chk("rand_drained", drn, 1);
      chk("rand_busy", busy2, 0);
      done2 = 1'b0;
    end

    bfpexp = -8'sd3;
    run0(1);

    // reset in the middle of a frame
    done = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    done = 1'b1;
    begin
      int cyc = 0;
      while (!(m_valid0 && m_index0 == 3'd4) && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("rst_reach_idx4", m_index0, 4);
    end
    rst = 1'b0;
    #1;
    chk_zero0("midrst");
    done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy0, 0);
    bfpexp = 8'sd1;
    run0(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
